dram_loader: RTL and testbench



---
 rtl/dram_loader.sv | 215 +++++++++++++++++++++
 tb/tb_dram_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_loader.sv
// Host-side DRAM loader: fills DRAM from a length-prefixed byte frame, starts the core, streams the result region out.
// Optional LOADER_CHECKSUM_EN appends an XOR checksum byte after the result bytes.
module dram_loader #(
  parameter logic [15:0] RESULT_BASE  = 16'h0000,
  parameter int          RESULT_LEN   = 16,
  parameter int          READ_LAT     = 2,
  parameter int          BUSY_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [15:0] o_dram_addr,
  output logic        o_dram_write,
  output logic        o_dram_read,
  output logic [7:0]  o_dram_out,
  input  logic [7:0]  i_dram_in,
  output logic        o_core_start,
  input  logic        i_core_busy,
  output logic        o_busy
);

  localparam logic [15:0] RLEN    = 16'(RESULT_LEN);
  localparam logic [15:0] RLAT_M1 = 16'(READ_LAT - 1);
  localparam logic [15:0] TOUT_M1 = 16'(BUSY_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_LEN_HI, S_LEN_LO, S_LOAD, S_START, S_WAIT_BUSY, S_RUN, S_RD_ISSUE, S_RD_WAIT, S_TX
`ifdef LOADER_CHECKSUM_EN
    , S_TX_CK
`endif
  } state_t;

  state_t      state_q, state_d;
  logic        live_q, live_d;
  logic        ldone_q, ldone_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] tmr_q, tmr_d;
  logic [15:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [7:0]  wdat_q, wdat_d;
  logic [7:0]  txd_q, txd_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  ck_q, ck_d;
`endif
  logic        rx_acc, tx_acc, rb_go, tx_end;

  // live_q keeps o_rx_ready low until the first edge after reset release
  assign o_rx_ready   = live_q & ((state_q == S_LEN_HI) | (state_q == S_LEN_LO) |
                                  ((state_q == S_LOAD) & ~ldone_q));
`ifdef LOADER_CHECKSUM_EN
  assign o_tx_valid   = (state_q == S_TX) | (state_q == S_TX_CK);
`else
  assign o_tx_valid   = (state_q == S_TX);
`endif
  assign o_tx_data    = txd_q;
  assign o_dram_addr  = addr_q;
  assign o_dram_write = wr_q;
  assign o_dram_out   = wdat_q;
  assign o_dram_read  = (state_q == S_RD_ISSUE);
  assign o_core_start = (state_q == S_START);
  assign o_busy       = (state_q != S_LEN_HI);
  assign rx_acc       = o_rx_ready & i_rx_valid;
  assign tx_acc       = o_tx_valid & i_tx_ready;

  always_comb begin
    state_d = state_q;
    live_d  = 1'b1;
    ldone_d = ldone_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    tmr_d   = tmr_q;
    addr_d  = addr_q;
    wr_d    = 1'b0;
    wdat_d  = wdat_q;
    txd_d   = txd_q;
`ifdef LOADER_CHECKSUM_EN
    ck_d    = ck_q;
`endif
    rb_go   = 1'b0;
    tx_end  = 1'b0;
    case (state_q)
      S_LEN_HI: if (rx_acc) begin
        len_d[15:8] = i_rx_data;
        state_d     = S_LEN_LO;
      end
      S_LEN_LO: if (rx_acc) begin
        len_d[7:0] = i_rx_data;
        cnt_d      = 16'd0;
        ptr_d      = 16'd0;
        ldone_d    = 1'b0;
        state_d    = ({len_q[15:8], i_rx_data} == 16'd0) ? S_START : S_LOAD;
      end
      S_LOAD: begin
        // Stay one extra cycle so the last write pulse finishes before START
        if (ldone_q) begin
          ldone_d = 1'b0;
          state_d = S_START;
        end else if (rx_acc) begin
          wr_d   = 1'b1;
          addr_d = ptr_q;
          wdat_d = i_rx_data;
          ptr_d  = ptr_q + 16'd1;
          cnt_d  = cnt_q + 16'd1;
          if (cnt_q == len_q - 16'd1) ldone_d = 1'b1;
        end
      end
      S_START: begin
        tmr_d   = 16'd1;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (i_core_busy)            state_d = S_RUN;
        else if (tmr_q >= TOUT_M1)  rb_go   = 1'b1;
        else                        tmr_d   = tmr_q + 16'd1;
      end
      S_RUN: if (!i_core_busy) rb_go = 1'b1;
      S_RD_ISSUE: begin
        tmr_d   = 16'd0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (tmr_q >= RLAT_M1) begin
          txd_d   = i_dram_in;
`ifdef LOADER_CHECKSUM_EN
          ck_d    = ck_q ^ i_dram_in;
`endif
          state_d = S_TX;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_TX: if (tx_acc) begin
        if (cnt_q == RLEN - 16'd1) begin
          tx_end = 1'b1;
        end else begin
          cnt_d   = cnt_q + 16'd1;
          addr_d  = addr_q + 16'd1;
          state_d = S_RD_ISSUE;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_TX_CK: if (tx_acc) state_d = S_LEN_HI;
`endif
      default: state_d = S_LEN_HI;
    endcase

    if (rb_go) begin
      addr_d = RESULT_BASE;
      cnt_d  = 16'd0;
`ifdef LOADER_CHECKSUM_EN
      ck_d   = 8'h00;
      if (RLEN == 16'd0) begin
        txd_d   = 8'h00;
        state_d = S_TX_CK;
      end else begin
        state_d = S_RD_ISSUE;
      end
`else
      state_d = (RLEN == 16'd0) ? S_LEN_HI : S_RD_ISSUE;
`endif
    end
    if (tx_end) begin
`ifdef LOADER_CHECKSUM_EN
      txd_d   = ck_q;
      state_d = S_TX_CK;
`else
      state_d = S_LEN_HI;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_LEN_HI;
      live_q  <= 1'b0;
      ldone_q <= 1'b0;
      len_q   <= 16'd0;
      cnt_q   <= 16'd0;
      ptr_q   <= 16'd0;
      tmr_q   <= 16'd0;
      addr_q  <= 16'd0;
      wr_q    <= 1'b0;
      wdat_q  <= 8'd0;
      txd_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      live_q  <= live_d;
      ldone_q <= ldone_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      tmr_q   <= tmr_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdat_q  <= wdat_d;
      txd_q   <= txd_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Checksum is cleared at every readback start, so it needs no reset
  always_ff @(posedge i_clk) begin
    ck_q <= ck_d;
  end
`endif

endmodule

// File: tb/tb_dram_loader.sv
// Directed bench for dram_loader: main instance (base 0x0010) and a wrap instance (base 0xFFFE, 4 bytes).
module tb_dram_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam int M_N = 17;
  localparam int W_N = 5;
`else
  localparam int M_N = 16;
  localparam int W_N = 4;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rx_valid, rx_ready, tx_valid, tx_ready, dram_write, dram_read, core_start, core_busy, busy;
  logic [7:0]  rx_data, tx_data, dram_out, dram_in;
  logic [15:0] dram_addr;
  logic        w_rst_n, w_rx_valid, w_rx_ready, w_tx_valid, w_tx_ready, w_dram_write, w_dram_read, w_core_start, w_core_busy, w_busy;
  logic [7:0]  w_rx_data, w_tx_data, w_dram_out, w_dram_in;
  logic [15:0] w_dram_addr;

  dram_loader #(.RESULT_BASE(16'h0010), .RESULT_LEN(16), .READ_LAT(2), .BUSY_TIMEOUT(16)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_dram_addr(dram_addr),
    .o_dram_write(dram_write), .o_dram_read(dram_read), .o_dram_out(dram_out), .i_dram_in(dram_in),
    .o_core_start(core_start), .i_core_busy(core_busy), .o_busy(busy));

  dram_loader #(.RESULT_BASE(16'hFFFE), .RESULT_LEN(4), .READ_LAT(2), .BUSY_TIMEOUT(16)) u_wrap (
    .i_clk(clk), .i_rst_n(w_rst_n), .i_rx_data(w_rx_data), .i_rx_valid(w_rx_valid), .o_rx_ready(w_rx_ready),
    .o_tx_data(w_tx_data), .o_tx_valid(w_tx_valid), .i_tx_ready(w_tx_ready), .o_dram_addr(w_dram_addr),
    .o_dram_write(w_dram_write), .o_dram_read(w_dram_read), .o_dram_out(w_dram_out), .i_dram_in(w_dram_in),
    .o_core_start(w_core_start), .i_core_busy(w_core_busy), .o_busy(w_busy));

  int total = 0;
  int bad = 0;

  // Read-only DRAM models with a 2-cycle read pipeline; 0xEE marks a cycle with no read strobe
  logic [7:0] mem   [0:65535];
  logic [7:0] w_mem [0:65535];
  logic [7:0] rp1 = 8'hEE, rp2 = 8'hEE, wp1 = 8'hEE, wp2 = 8'hEE;
  always @(posedge clk) begin
    rp1 <= dram_read ? mem[dram_addr] : 8'hEE;
    rp2 <= rp1;
    wp1 <= w_dram_read ? w_mem[w_dram_addr] : 8'hEE;
    wp2 <= wp1;
  end
  assign dram_in   = rp2;
  assign w_dram_in = wp2;

  int cyc = 0;
  int clash = 0;
  int unstable = 0;
  bit hold_pend = 1'b0;
  logic [7:0] hold_val = 8'h00;
  logic [15:0] wr_addr[$], rd_addr[$], w_rd_addr[$];
  logic [7:0]  wr_data[$], tx_q[$], w_tx_q[$], w_wr_data[$];
  int wr_cyc[$], rd_cyc[$], st_cyc[$], acc_cyc[$];
  int w_rd_cyc[$], w_st_cyc[$], w_acc_cyc[$];

  always @(posedge clk) begin
    if (dram_write) begin wr_addr.push_back(dram_addr); wr_data.push_back(dram_out); wr_cyc.push_back(cyc); end
    if (dram_read) begin rd_addr.push_back(dram_addr); rd_cyc.push_back(cyc); end
    if ((dram_read && dram_write) || (w_dram_read && w_dram_write)) clash++;
    if (core_start) st_cyc.push_back(cyc);
    if (rx_valid && rx_ready) acc_cyc.push_back(cyc);
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (hold_pend && tx_valid && tx_data != hold_val) unstable++;
    hold_pend = tx_valid && !tx_ready && rst_n;
    hold_val  = tx_data;
    if (w_dram_write) w_wr_data.push_back(w_dram_out);
    if (w_dram_read) begin w_rd_addr.push_back(w_dram_addr); w_rd_cyc.push_back(cyc); end
    if (w_core_start) w_st_cyc.push_back(cyc);
    if (w_rx_valid && w_rx_ready) w_acc_cyc.push_back(cyc);
    if (w_tx_valid && w_tx_ready) w_tx_q.push_back(w_tx_data);
    cyc++;
  end

  // Core model: busy high for 50 cycles starting 2 cycles after the start pulse
  bit core_en = 1'b0;
  int kc = 0;
  always @(negedge clk) begin
    if (!core_en) begin
      kc = 0;
    end else begin
      if (core_start) kc = 1;
      else if (kc > 0) kc = kc + 1;
      if (kc > 52) kc = 0;
    end
    core_busy = (kc >= 3 && kc <= 52);
  end

  bit tog_en = 1'b0;
  logic tx_hold = 1'b0;
  always @(negedge clk) tx_ready = tog_en ? ~tx_ready : tx_hold;

  logic [7:0] fq[$];
  task automatic send_frame(input bit to_w);
    int n;
    for (int i = 0; i < fq.size(); i++) begin
      @(negedge clk);
      if (to_w) begin w_rx_valid = 1'b1; w_rx_data = fq[i]; end
      else begin rx_valid = 1'b1; rx_data = fq[i]; end
      n = 0;
      while (!(to_w ? w_rx_ready : rx_ready) && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin total++; bad++; $display("FAIL send_ready byte=%0d got ready=0 want 1", i); end
      @(posedge clk);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    w_rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; w_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({tx_valid, rx_ready, busy, dram_write, dram_read, core_start, dram_addr, dram_out, tx_data} !== 43'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {tx_valid, rx_ready, busy, dram_write, dram_read, core_start, dram_addr, dram_out, tx_data});
    end
    rst_n = 1'b1; w_rst_n = 1'b1;
    total++;
    if (rx_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%b want=0", rx_ready); end
    @(negedge clk);
    total++;
    if (rx_ready !== 1'b1) begin bad++; $display("FAIL ready_after_release got=%b want=1", rx_ready); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_after_release got=%b want=0", busy); end
    total++;
    if (w_rx_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready_after_release got=%b want=1", w_rx_ready); end
  endtask

  task automatic test_load();
    logic [7:0] exp_d [3] = '{8'hAA, 8'hBB, 8'hCC};
    core_en = 1'b1;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); st_cyc.delete(); acc_cyc.delete();
    fq = '{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    send_frame(1'b0);
    repeat (3) @(negedge clk);
    total++;
    if (wr_addr.size() !== 3) begin bad++; $display("FAIL load_write_count got=%0d want=3", wr_addr.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (wr_addr[i] !== 16'(i) || wr_data[i] !== exp_d[i]) begin
          bad++; $display("FAIL load_write%0d got=%h@%h want=%h@%h", i, wr_data[i], wr_addr[i], exp_d[i], 16'(i));
        end
      end
      total++;
      if (wr_cyc[0] !== acc_cyc[2] + 1 || wr_cyc[1] !== wr_cyc[0] + 1 || wr_cyc[2] !== wr_cyc[1] + 1) begin
        bad++; $display("FAIL load_write_timing got=%0d,%0d,%0d want=%0d,+1,+2", wr_cyc[0], wr_cyc[1], wr_cyc[2], acc_cyc[2] + 1);
      end
      total++;
      if (st_cyc.size() !== 1 || st_cyc[0] !== wr_cyc[2] + 1) begin
        bad++; $display("FAIL load_start got_n=%0d got_cyc=%0d want_n=1 want_cyc=%0d", st_cyc.size(), st_cyc[0], wr_cyc[2] + 1);
      end
    end
    total++;
    if (rx_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL load_after_ready_busy got=%b%b want=01", rx_ready, busy); end
  endtask

  task automatic test_readback();
    logic [7:0] e;
    rd_addr.delete(); rd_cyc.delete(); tx_q.delete();
    clash = 0; unstable = 0;
    tog_en = 1'b1;
    for (int i = 0; i < 1500 && tx_q.size() < M_N; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    tog_en = 1'b0; tx_hold = 1'b0;
    total++;
    if (tx_q.size() !== M_N) begin bad++; $display("FAIL rb_byte_count got=%0d want=%0d", tx_q.size(), M_N); end
    for (int i = 0; i < M_N && i < tx_q.size(); i++) begin
      e = (i < 16) ? 8'(i + 1) : 8'h10;
      total++;
      if (tx_q[i] !== e) begin bad++; $display("FAIL rb_byte%0d got=%h want=%h", i, tx_q[i], e); end
    end
    total++;
    if (rd_addr.size() !== 16) begin bad++; $display("FAIL rb_read_count got=%0d want=16", rd_addr.size()); end
    for (int i = 0; i < 16 && i < rd_addr.size(); i++) begin
      total++;
      if (rd_addr[i] !== 16'(16 + i)) begin bad++; $display("FAIL rb_addr%0d got=%h want=%h", i, rd_addr[i], 16'(16 + i)); end
    end
    total++;
    if (rd_cyc.size() < 1 || rd_cyc[0] !== st_cyc[0] + 53) begin
      bad++; $display("FAIL rb_first_read_cycle got=%0d want=%0d", rd_cyc[0], st_cyc[0] + 53);
    end
    total++;
    if (clash !== 0) begin bad++; $display("FAIL rb_read_write_overlap got=%0d want=0", clash); end
    total++;
    if (unstable !== 0) begin bad++; $display("FAIL rb_tx_stable got=%0d want=0", unstable); end
    total++;
    if (busy !== 1'b0 || rx_ready !== 1'b1) begin bad++; $display("FAIL rb_return_idle got=%b%b want=01", busy, rx_ready); end
  endtask

  task automatic test_wrap_zero();
    logic [15:0] ea [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    logic [7:0]  ed [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h04};
    w_tx_ready = 1'b1;
    fq = '{8'h00, 8'h00};
    send_frame(1'b1);
    for (int i = 0; i < 400 && w_tx_q.size() < W_N; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    total++;
    if (w_wr_data.size() !== 0) begin bad++; $display("FAIL zero_no_writes got=%0d want=0", w_wr_data.size()); end
    total++;
    if (w_st_cyc.size() !== 1 || w_acc_cyc.size() !== 2 || w_st_cyc[0] !== w_acc_cyc[1] + 1) begin
      bad++; $display("FAIL zero_start got_n=%0d got_cyc=%0d want_cyc=%0d", w_st_cyc.size(), w_st_cyc[0], w_acc_cyc[1] + 1);
    end
    total++;
    if (w_rd_addr.size() !== 4) begin bad++; $display("FAIL wrap_read_count got=%0d want=4", w_rd_addr.size()); end
    for (int i = 0; i < 4 && i < w_rd_addr.size(); i++) begin
      total++;
      if (w_rd_addr[i] !== ea[i]) begin bad++; $display("FAIL wrap_addr%0d got=%h want=%h", i, w_rd_addr[i], ea[i]); end
    end
    total++;
    if (w_rd_cyc.size() < 2 || w_rd_cyc[0] !== w_st_cyc[0] + 16) begin
      bad++; $display("FAIL timeout_first_read got=%0d want=%0d", w_rd_cyc[0], w_st_cyc[0] + 16);
    end
    total++;
    if (w_rd_cyc.size() < 2 || w_rd_cyc[1] - w_rd_cyc[0] !== 4) begin
      bad++; $display("FAIL wrap_read_spacing got=%0d want=4", w_rd_cyc[1] - w_rd_cyc[0]);
    end
    total++;
    if (w_tx_q.size() !== W_N) begin bad++; $display("FAIL wrap_byte_count got=%0d want=%0d", w_tx_q.size(), W_N); end
    for (int i = 0; i < W_N && i < w_tx_q.size(); i++) begin
      total++;
      if (w_tx_q[i] !== ed[i]) begin bad++; $display("FAIL wrap_byte%0d got=%h want=%h", i, w_tx_q[i], ed[i]); end
    end
    total++;
    if (w_busy !== 1'b0) begin bad++; $display("FAIL wrap_return_idle got=%b want=0", w_busy); end
  endtask

  task automatic test_midreset();
    int n;
    tx_hold = 1'b0;
    fq = '{8'h00, 8'h01, 8'h55};
    send_frame(1'b0);
    n = 0;
    while (!tx_valid && n < 300) begin @(negedge clk); n++; end
    total++;
    if (tx_valid !== 1'b1) begin bad++; $display("FAIL midrst_reach_tx got=%b want=1", tx_valid); end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({tx_valid, busy, dram_read, dram_write, rx_ready} !== 5'b0) begin
      bad++; $display("FAIL midrst_outputs got=%b want=00000", {tx_valid, busy, dram_read, dram_write, rx_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    wr_addr.delete(); wr_data.delete();
    @(negedge clk);
    fq = '{8'h00, 8'h02, 8'h11, 8'h22};
    send_frame(1'b0);
    repeat (3) @(negedge clk);
    total++;
    if (wr_addr.size() !== 2 || wr_addr[0] !== 16'h0000 || wr_data[0] !== 8'h11 || wr_addr[1] !== 16'h0001 || wr_data[1] !== 8'h22) begin
      bad++; $display("FAIL midrst_reload got_n=%0d first=%h@%h want 11@0000,22@0001", wr_addr.size(), wr_data[0], wr_addr[0]);
    end
  endtask

  initial begin
    rx_valid = 1'b0; rx_data = 8'h00; w_rx_valid = 1'b0; w_rx_data = 8'h00;
    w_tx_ready = 1'b0; w_core_busy = 1'b0;
    for (int i = 0; i < 65536; i++) begin mem[i] = 8'h5A; w_mem[i] = 8'h5A; end
    for (int i = 0; i < 16; i++) mem[16 + i] = 8'(i + 1);
    w_mem[16'hFFFE] = 8'hA1; w_mem[16'hFFFF] = 8'hA2; w_mem[16'h0000] = 8'hA3; w_mem[16'h0001] = 8'hA4;
    test_reset();
    test_load();
    test_readback();
    test_wrap_zero();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
